// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared opcodes, widths and default geometry for the SPI RAM controller
package spi_ram_pkg;
  localparam int CMD_W         = 10;
  localparam int DATA_W        = 8;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_ADDR_SIZE = 8;
  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } opcode_e;
endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: single-port RAM, sync write, registered read; parity column when SPI_RAM_PARITY_EN is defined
module spi_ram_mem
  import spi_ram_pkg::*;
#(
  parameter int DEPTH = DEF_MEM_DEPTH,
  parameter int AW    = DEF_ADDR_SIZE
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef SPI_RAM_PARITY_EN
  output logic              rpar_o,
`endif
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
`ifdef SPI_RAM_PARITY_EN
  logic par_q [DEPTH];
  logic rpar_q;
  // Even-parity bit stored alongside each word and read out with it
  always_ff @(posedge clk) begin
    if (we_i) par_q[addr_i] <= ^wdata_i;
    if (re_i) rpar_q <= par_q[addr_i];
  end
  assign rpar_o = rpar_q;
`endif
  // Storage is deliberately not reset; read data is registered
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder, independent wr/rd pointers, tx pipeline; SPI_RAM_PARITY_EN enables parity check
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [CMD_W-1:0]  rx_data,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              parity_err
);
  opcode_e             op;
  logic                mem_we, mem_re;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_W-1:0]   mem_rdata;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                pend_q, pend_d, tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  assign op       = opcode_e'(rx_data[CMD_W-1:DATA_W]);
  assign mem_we   = rx_valid && op == OP_WR_DATA;
  assign mem_re   = rx_valid && op == OP_RD_DATA;
  assign mem_addr = mem_re ? rd_addr_q : wr_addr_q;
`ifdef SPI_RAM_PARITY_EN
  logic mem_rpar, parity_err_q, parity_err_d;
`endif
  spi_ram_mem #(.DEPTH(MEM_DEPTH), .AW(ADDR_SIZE)) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (mem_addr),
    .wdata_i (rx_data[DATA_W-1:0]),
`ifdef SPI_RAM_PARITY_EN
    .rpar_o  (mem_rpar),
`endif
    .rdata_o (mem_rdata)
  );
  // Pointer updates and the two-stage read pipeline (mem register, then tx register)
  always_comb begin
    wr_addr_d  = rx_valid && op == OP_WR_ADDR ? rx_data[ADDR_SIZE-1:0] :
                 mem_we ? wr_addr_q + ADDR_SIZE'(1) : wr_addr_q;
    rd_addr_d  = rx_valid && op == OP_RD_ADDR ? rx_data[ADDR_SIZE-1:0] :
                 mem_re ? rd_addr_q + ADDR_SIZE'(1) : rd_addr_q;
    pend_d     = mem_re;
    tx_valid_d = pend_q;
    tx_data_d  = pend_q ? mem_rdata : tx_data_q;
  end
  // Control state with asynchronous clear; a reset drops any pending read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      pend_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      pend_q     <= pend_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
`ifdef SPI_RAM_PARITY_EN
  // Sticky parity error, raised in the tx_valid cycle of a bad read
  always_comb parity_err_d = parity_err_q | (pend_q && ((^mem_rdata) != mem_rpar));
  // Parity flag register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else parity_err_q <= parity_err_d;
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: table-driven directed bench for spi_ram_ctrl (parity section under SPI_RAM_PARITY_EN)
module tb_spi_ram_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] rx_data;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       parity_err;
  int         n_vec = 0;
  int         n_err = 0;
  logic       exp_perr = 1'b0;

  typedef struct {
    logic       v;
    logic [9:0] d;
    logic       ev;
    logic [7:0] ed;
  } vec_t;
  vec_t tbl[$];

  spi_ram_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] wa(input logic [7:0] a); return {2'b00, a}; endfunction
  function automatic logic [9:0] wd(input logic [7:0] a); return {2'b01, a}; endfunction
  function automatic logic [9:0] ra(input logic [7:0] a); return {2'b10, a}; endfunction
  function automatic logic [9:0] rd(); return {2'b11, 8'h00}; endfunction

  function automatic vec_t mk(input logic v, input logic [9:0] d, input logic ev, input logic [7:0] ed);
    vec_t r;
    r.v = v; r.d = d; r.ev = ev; r.ed = ed;
    return r;
  endfunction

  task automatic check(input string nm, input logic ev, input logic [7:0] ed);
    n_vec++;
    if ({tx_valid, tx_data, parity_err} !== {ev, ed, exp_perr}) begin
      n_err++;
      $display("FAIL %s: got tx_valid=%b tx_data=%h parity_err=%b, want tx_valid=%b tx_data=%h parity_err=%b",
               nm, tx_valid, tx_data, parity_err, ev, ed, exp_perr);
    end
  endtask

  task automatic step(input logic v, input logic [9:0] d, input logic ev, input logic [7:0] ed, input string nm);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    check(nm, ev, ed);
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    #1 check("reset", 1'b0, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    tbl.push_back(mk(1, wa(8'h10), 0, 8'h00));
    tbl.push_back(mk(1, wd(8'hA5), 0, 8'h00));
    tbl.push_back(mk(1, ra(8'h10), 0, 8'h00));
    tbl.push_back(mk(1, rd(),      0, 8'h00));
    tbl.push_back(mk(0, 10'h3FF,   1, 8'hA5));
    tbl.push_back(mk(0, 10'h155,   0, 8'hA5));
    tbl.push_back(mk(1, wa(8'hFF), 0, 8'hA5));
    tbl.push_back(mk(1, wd(8'h11), 0, 8'hA5));
    tbl.push_back(mk(1, wd(8'h22), 0, 8'hA5));
    tbl.push_back(mk(1, ra(8'hFF), 0, 8'hA5));
    tbl.push_back(mk(1, rd(),      0, 8'hA5));
    tbl.push_back(mk(1, rd(),      1, 8'h11));
    tbl.push_back(mk(0, 10'h000,   1, 8'h22));
    tbl.push_back(mk(0, 10'h000,   0, 8'h22));
    tbl.push_back(mk(1, wa(8'h40), 0, 8'h22));
    tbl.push_back(mk(1, wd(8'h3C), 0, 8'h22));
    tbl.push_back(mk(1, ra(8'h40), 0, 8'h22));
    tbl.push_back(mk(1, rd(),      0, 8'h22));
    tbl.push_back(mk(0, 10'h000,   1, 8'h3C));
    tbl.push_back(mk(1, wa(8'h50), 0, 8'h3C));
    tbl.push_back(mk(1, ra(8'h50), 0, 8'h3C));
    tbl.push_back(mk(1, wd(8'h77), 0, 8'h3C));
    tbl.push_back(mk(1, rd(),      0, 8'h3C));
    tbl.push_back(mk(0, 10'h000,   1, 8'h77));
    tbl.push_back(mk(1, wd(8'h88), 0, 8'h77));
    tbl.push_back(mk(1, wa(8'h00), 0, 8'h77));
    tbl.push_back(mk(1, rd(),      0, 8'h77));
    tbl.push_back(mk(0, 10'h000,   1, 8'h88));
    tbl.push_back(mk(1, ra(8'h10), 0, 8'h88));
    tbl.push_back(mk(1, wd(8'h99), 0, 8'h88));
    tbl.push_back(mk(1, ra(8'h00), 0, 8'h88));
    tbl.push_back(mk(1, rd(),      0, 8'h88));
    tbl.push_back(mk(0, 10'h000,   1, 8'h99));
    foreach (tbl[i]) step(tbl[i].v, tbl[i].d, tbl[i].ev, tbl[i].ed, $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) step(1'b0, 10'($urandom), 1'b0, 8'h99, "idle_hold");
    step(1, ra(8'hFF), 0, 8'h99, "idle_rd_addr");
    step(1, rd(),      0, 8'h99, "idle_rd0");
    step(1, rd(),      1, 8'h11, "idle_rd_ff");
    step(0, 10'h000,   1, 8'h99, "idle_rd_00");
    step(1, wd(8'h5A), 0, 8'h99, "idle_wr_ptr");
    step(1, ra(8'h01), 0, 8'h99, "idle_ra01");
    step(1, rd(),      0, 8'h99, "idle_rd01");
    step(0, 10'h000,   1, 8'h5A, "idle_wr_ptr_kept");
    step(1, ra(8'h10), 0, 8'h5A, "idle_ra10");
    step(1, rd(),      0, 8'h5A, "idle_rd10");
    step(0, 10'h000,   1, 8'hA5, "idle_mem_kept");

    step(1, ra(8'h10), 0, 8'hA5, "rst_setup");
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = rd();
    @(posedge clk);
    #2 rst_n = 1'b0;
    rx_valid = 1'b0;
    #1 check("rst_async", 1'b0, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    step(0, 10'h000,   0, 8'h00, "rst_cancel");
    step(1, wd(8'h42), 0, 8'h00, "rst_wr0");
    step(1, rd(),      0, 8'h00, "rst_rd0");
    step(0, 10'h000,   1, 8'h42, "rst_ptrs_zero");

`ifdef SPI_RAM_PARITY_EN
    step(1, wa(8'h05), 0, 8'h42, "par_wa");
    step(1, wd(8'h0F), 0, 8'h42, "par_wd");
    @(negedge clk) dut.u_mem.mem_q[5] = 8'h0E;
    step(1, ra(8'h05), 0, 8'h42, "par_ra");
    step(1, rd(),      0, 8'h42, "par_rd");
    exp_perr = 1'b1;
    step(0, 10'h000,   1, 8'h0E, "par_err_set");
    step(0, 10'h000,   0, 8'h0E, "par_err_sticky");
    step(1, wa(8'h20), 0, 8'h0E, "par_err_sticky2");
    @(negedge clk) rst_n = 1'b0;
    exp_perr = 1'b0;
    #1 check("par_err_reset", 1'b0, 8'h00);
    @(negedge clk) rst_n = 1'b1;
`else
    step(1, wa(8'h05), 0, 8'h42, "nopar_wa");
    step(1, wd(8'h0F), 0, 8'h42, "nopar_wd");
    step(1, ra(8'h05), 0, 8'h42, "nopar_ra");
    step(1, rd(),      0, 8'h42, "nopar_rd");
    step(0, 10'h000,   1, 8'h0F, "nopar_zero");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit words stored.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address width; MEM_DEPTH SHALL equal 2**ADDR_SIZE.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe marking rx_data as a complete command word from the SPI slave.
REQ-006 SHALL have port rx_data  input  10  command word: [9:8] opcode, [7:0] address or data payload.
REQ-007 SHALL have port tx_valid  output  1  one-cycle strobe marking tx_data as read data for the SPI slave.
REQ-008 SHALL have port tx_data  output  8  read data word.
REQ-009 SHALL have port parity_err  output  1  sticky flag, set on a read parity mismatch.

Function
REQ-010 Opcodes SHALL be 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA, decoded only in cycles where rx_valid=1.
REQ-011 WR_ADDR SHALL load wr_addr <= rx_data[ADDR_SIZE-1:0].
REQ-012 WR_DATA SHALL write mem[wr_addr] <= rx_data[7:0], then increment wr_addr modulo MEM_DEPTH (0xFF wraps to 0x00).
REQ-013 RD_ADDR SHALL load rd_addr <= rx_data[ADDR_SIZE-1:0].
REQ-014 RD_DATA SHALL register mem[rd_addr] into tx_data, then increment rd_addr modulo MEM_DEPTH; rx_data[7:0] is ignored.
REQ-015 Read latency SHALL be 1 cycle: a RD_DATA accepted at edge N SHALL give tx_valid=1 and valid tx_data in the cycle after edge N+1.
REQ-016 tx_valid SHALL be high for exactly one cycle per RD_DATA, and low otherwise.
REQ-017 tx_data SHALL hold its last value when tx_valid=0.
REQ-018 When rx_valid=0, the block SHALL keep memory, addresses, tx_data and parity_err unchanged.
REQ-019 A RD_DATA on the cycle after a WR_DATA to the same address SHALL return the newly written data, with no stale-read hazard.
REQ-020 Back-to-back RD_DATA on consecutive cycles SHALL produce consecutive tx_valid pulses with sequential addresses.
REQ-021 The write and read address pointers SHALL be independent; a WR_ADDR SHALL NOT alter rd_addr, and a RD_ADDR SHALL NOT alter wr_addr.
REQ-022 The block SHALL apply no back-pressure and SHALL accept a command in every cycle.

Reset
REQ-023 While rst_n=0, the block SHALL force tx_valid=0, tx_data=0, wr_addr=0, rd_addr=0 and parity_err=0, independent of clk.
REQ-024 Memory contents SHALL NOT be reset; a read before any write returns an undefined value.
REQ-025 A reset asserted between RD_DATA acceptance and the tx_valid cycle SHALL cancel the pending tx_valid pulse.

Configuration
REQ-026 Macro SPI_RAM_PARITY_EN SHALL, when defined, store an even-parity bit per word on WR_DATA, check it on RD_DATA, and set parity_err on mismatch in the tx_valid cycle; parity_err clears only on reset.
REQ-027 Without SPI_RAM_PARITY_EN, the block SHALL store no parity bit, and parity_err SHALL be tied to 0.

Structure
REQ-028 Package spi_ram_pkg SHALL hold the opcode constants, command and data widths, and the default MEM_DEPTH and ADDR_SIZE values.
REQ-029 Storage SHALL sit in one sub-module, spi_ram_mem: single-port array, synchronous write, registered read, and optional parity column.
REQ-030 spi_ram_ctrl SHALL hold the decoder, the address pointers, the tx_valid pipeline and the parity check.

Verification
REQ-031 Basic write/read: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA -> one-cycle tx_valid with tx_data=0xA5, one cycle after the RD_DATA strobe.
REQ-032 Auto-increment and wrap: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22; RD_ADDR 0xFF, two RD_DATA -> tx_data 0x11 then 0x22, with the second read from address 0x00.
REQ-033 Idle hold: rx_valid=0 for 20 cycles with random rx_data -> no tx_valid, memory and pointers unchanged on a subsequent readback.
REQ-034 Reset mid-read: RD_DATA accepted, rst_n low before the next edge -> no tx_valid, tx_data=0, both pointers 0.
REQ-035 Back-to-back: WR_DATA 0x3C at address 0x40, then RD_ADDR 0x40 and RD_DATA on consecutive cycles -> tx_data=0x3C, no stale value.
REQ-036 Parity (SPI_RAM_PARITY_EN only): force a flipped bit in the stored word at 0x05, RD_DATA -> parity_err=1 and it stays 1 until reset; without the macro, parity_err=0 throughout.
